// File: rtl/vec_seq_pkg.sv
// Shared types and defaults for the vector element sequencer.
package vec_seq_pkg;

  localparam int MAX_VLEN_DEF = 16;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

endpackage

// File: rtl/vec_idx_counter.sv
// Saturating up-counter with synchronous clear. It stops at 'limit' and flags at_limit.
module vec_idx_counter #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             en,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             at_limit
);

  assign at_limit = (count == limit);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (en && !at_limit) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/vec_elem_seq.sv
// Issues element indices 0..vlen-1 for one vector instruction under valid/ready,
// counts writebacks and pulses done once every issued element has retired.
module vec_elem_seq
  import vec_seq_pkg::*;
#(
  parameter int MAX_VLEN = MAX_VLEN_DEF,
  parameter int IDX_W    = $clog2(MAX_VLEN),
  parameter int CNT_W    = $clog2(MAX_VLEN + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [CNT_W-1:0] cmd_vlen,
  output logic             elem_valid,
  input  logic             elem_ready,
  output logic [IDX_W-1:0] elem_idx,
  output logic             elem_last,
  input  logic             wb_valid,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             err
);

  state_t           state, state_nx;
  logic [CNT_W-1:0] vlen_q, vlen_clamp;
  logic [CNT_W-1:0] issue_cnt, wb_cnt;
  logic             issue_at_lim, wb_at_lim;
  logic             accept, issue_fire, wb_ok, clear_cnt;
  logic [CNT_W:0]   wb_sum;

  assign vlen_clamp = (cmd_vlen > CNT_W'(MAX_VLEN)) ? CNT_W'(MAX_VLEN) : cmd_vlen;
  assign accept     = (state == IDLE) && cmd_valid && !abort;
  assign issue_fire = elem_valid && elem_ready;
  assign clear_cnt  = accept || abort;

  // A writeback is legal only for an element already issued or issued this same cycle.
  assign wb_ok  = wb_valid && ((wb_cnt < issue_cnt) || issue_fire);
  assign wb_sum = {1'b0, wb_cnt} + {{CNT_W{1'b0}}, wb_ok};

  vec_idx_counter #(.WIDTH(CNT_W)) u_issue_cnt (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear_cnt),
    .en       (issue_fire),
    .limit    (vlen_q),
    .count    (issue_cnt),
    .at_limit (issue_at_lim)
  );

  vec_idx_counter #(.WIDTH(CNT_W)) u_wb_cnt (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear_cnt),
    .en       (wb_ok),
    .limit    (vlen_q),
    .count    (wb_cnt),
    .at_limit (wb_at_lim)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      vlen_q <= '0;
      err    <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        vlen_q <= vlen_clamp;
      end
      if (wb_valid && !wb_ok) begin
        err <= 1'b1;
      end
    end
  end

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_nx   = state;
    cmd_ready  = 1'b0;
    elem_valid = 1'b0;
    elem_last  = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (accept) begin
          state_nx = (vlen_clamp == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        elem_valid = !issue_at_lim;
        elem_last  = elem_valid && (issue_cnt == vlen_q - CNT_W'(1));
        if (issue_fire && elem_last) begin
          state_nx = (wb_sum == {1'b0, vlen_q}) ? DONE : DRAIN;
        end
      end
      DRAIN: begin
        // Look at the incoming writeback so done follows the final one by one cycle.
        if (wb_at_lim || (wb_sum == {1'b0, vlen_q})) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    if (abort) begin
      state_nx = IDLE;
    end
  end

  assign busy     = (state != IDLE);
  assign elem_idx = issue_cnt[IDX_W-1:0];

endmodule

// File: tb/tb_vec_elem_seq.sv
// Self-checking bench for vec_elem_seq: table-driven commands, hand-written corner
// sequences and randomized commands checked against a count-based reference model.
module tb_vec_elem_seq;

  localparam int MAX_VLEN = 16;
  localparam int IDX_W    = 4;
  localparam int CNT_W    = 5;

  logic             clk = 1'b0;
  logic             reset;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [CNT_W-1:0] cmd_vlen;
  logic             elem_valid;
  logic             elem_ready;
  logic [IDX_W-1:0] elem_idx;
  logic             elem_last;
  logic             wb_valid;
  logic             abort;
  logic             busy;
  logic             done;
  logic             err;

  int n_tests = 0;
  int n_fail  = 0;
  logic err_exp = 1'b0;

  typedef struct {
    int vlen;
    int exp_n;
    int rdy_pct;
    bit toggle;
    int wb_pct;
    bit wb_same;
  } vec_t;

  vec_elem_seq #(.MAX_VLEN(MAX_VLEN)) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_vlen   (cmd_vlen),
    .elem_valid (elem_valid),
    .elem_ready (elem_ready),
    .elem_idx   (elem_idx),
    .elem_last  (elem_last),
    .wb_valid   (wb_valid),
    .abort      (abort),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one full command from IDLE; the model tracks only issued/retired counts.
  task automatic run_cmd(input int vlen, input int exp_n, input int rdy_pct, input bit toggle,
                         input int wb_pct, input bit wb_same);
    int issued = 0;
    int retired = 0;
    int seen = 0;
    int cyc = 0;
    bit fin = 0;
    bit exp_valid, exp_done, issue_now;
    cmd_valid  = 1'b1;
    cmd_vlen   = CNT_W'(vlen);
    elem_ready = 1'b0;
    wb_valid   = 1'b0;
    abort      = 1'b0;
    @(negedge clk);
    check("accept_ready", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
    cmd_vlen  = CNT_W'($urandom);
    while (!fin) begin
      exp_valid  = issued < exp_n;
      exp_done   = (issued == exp_n) && (retired == exp_n);
      elem_ready = toggle ? (cyc % 2 == 0) : ($urandom_range(99) < rdy_pct);
      issue_now  = exp_valid && elem_ready;
      wb_valid   = (retired < issued + ((wb_same && issue_now) ? 1 : 0)) &&
                   ($urandom_range(99) < wb_pct);
      @(negedge clk);
      check("elem_valid", elem_valid, exp_valid);
      if (exp_valid) begin
        check("elem_idx", elem_idx, issued);
        check("elem_last", elem_last, issued == exp_n - 1);
      end
      check("done", done, exp_done);
      check("busy", busy, 1);
      check("err", err, err_exp);
      if (elem_valid && elem_ready) seen++;
      tick();
      if (issue_now) issued++;
      if (wb_valid) retired++;
      if (exp_done) fin = 1;
      cyc++;
      if (!fin && cyc > 400) begin
        check("timeout_done", fin, 1);
        fin = 1;
      end
    end
    elem_ready = 1'b0;
    wb_valid   = 1'b0;
    @(negedge clk);
    check("seen_count", seen, exp_n);
    check("idle_ready", cmd_ready, 1);
    check("idle_done", done, 0);
    check("idle_busy", busy, 0);
    tick();
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{vlen: 4,  exp_n: 4,  rdy_pct: 100, toggle: 1'b0, wb_pct: 100, wb_same: 1'b0};
    vecs[1] = '{vlen: 3,  exp_n: 3,  rdy_pct: 100, toggle: 1'b1, wb_pct: 100, wb_same: 1'b0};
    vecs[2] = '{vlen: 0,  exp_n: 0,  rdy_pct: 100, toggle: 1'b0, wb_pct: 100, wb_same: 1'b0};
    vecs[3] = '{vlen: 20, exp_n: 16, rdy_pct: 100, toggle: 1'b0, wb_pct: 100, wb_same: 1'b0};
    vecs[4] = '{vlen: 16, exp_n: 16, rdy_pct: 70,  toggle: 1'b0, wb_pct: 60,  wb_same: 1'b1};
    vecs[5] = '{vlen: 1,  exp_n: 1,  rdy_pct: 100, toggle: 1'b0, wb_pct: 100, wb_same: 1'b1};
    vecs[6] = '{vlen: 31, exp_n: 16, rdy_pct: 50,  toggle: 1'b0, wb_pct: 40,  wb_same: 1'b0};

    reset      = 1'b1;
    cmd_valid  = 1'b0;
    cmd_vlen   = '0;
    elem_ready = 1'b0;
    wb_valid   = 1'b0;
    abort      = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_elem_valid", elem_valid, 0);
    check("rst_elem_last", elem_last, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    tick();

    for (int i = 0; i < 7; i++) begin
      run_cmd(vecs[i].vlen, vecs[i].exp_n, vecs[i].rdy_pct, vecs[i].toggle,
              vecs[i].wb_pct, vecs[i].wb_same);
    end

    // Abort after three accepted elements of an 8-element command.
    cmd_valid  = 1'b1;
    cmd_vlen   = CNT_W'(8);
    elem_ready = 1'b1;
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_pre_idx", elem_idx, i);
      tick();
    end
    abort      = 1'b1;
    elem_ready = 1'b0;
    tick();
    abort = 1'b0;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_cmd_ready", cmd_ready, 1);
    check("abort_elem_valid", elem_valid, 0);
    for (int i = 0; i < 4; i++) begin
      check("abort_no_done", done, 0);
      tick();
      @(negedge clk);
    end
    tick();

    // abort wins over a command presented in IDLE.
    cmd_valid = 1'b1;
    cmd_vlen  = CNT_W'(5);
    abort     = 1'b1;
    tick();
    cmd_valid = 1'b0;
    abort     = 1'b0;
    @(negedge clk);
    check("abort_prio_busy", busy, 0);
    check("abort_prio_valid", elem_valid, 0);
    tick();
    run_cmd(2, 2, 100, 1'b0, 100, 1'b0);

    // Reset in the middle of a command.
    cmd_valid  = 1'b1;
    cmd_vlen   = CNT_W'(5);
    elem_ready = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    elem_ready = 1'b0;
    @(negedge clk);
    check("midrst_busy", busy, 0);
    check("midrst_valid", elem_valid, 0);
    tick();

    // Stray writeback in IDLE sets the sticky error.
    wb_valid = 1'b1;
    tick();
    wb_valid = 1'b0;
    err_exp  = 1'b1;
    @(negedge clk);
    check("err_set", err, 1);
    tick();
    run_cmd(2, 2, 100, 1'b0, 100, 1'b0);
    @(negedge clk);
    check("err_sticky", err, 1);
    tick();
    reset = 1'b1;
    tick();
    reset   = 1'b0;
    err_exp = 1'b0;
    @(negedge clk);
    check("err_cleared", err, 0);
    tick();

    // Randomized commands against the count model.
    for (int i = 0; i < 30; i++) begin
      int v;
      v = $urandom_range(31);
      run_cmd(v, (v > MAX_VLEN) ? MAX_VLEN : v, $urandom_range(100, 20), 1'b0,
              $urandom_range(100, 20), 1'($urandom_range(1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vec_elem_seq.md
Name: vec_elem_seq

Overview:
- Sequences one vector instruction over its elements. Accepts a command carrying a vector length, then issues element indices 0..vlen-1 to the lane datapath under valid/ready backpressure.
- Counts element writebacks and pulses done when all have retired.
- Sits between the instruction decode/issue stage and the element datapath. Replaces free-running enable-driven counters with a controlled, handshaked loop.

Parameters:
MAX_VLEN, 16, maximum elements per instruction (power of two, >=2)
IDX_W, $clog2(MAX_VLEN) = 4, element index width
CNT_W, $clog2(MAX_VLEN+1) = 5, element count width (holds MAX_VLEN)

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
cmd_valid  input  1  command present
cmd_ready  output  1  sequencer can accept a command
cmd_vlen  input  CNT_W  element count for the command
elem_valid  output  1  element index offered to datapath
elem_ready  input  1  datapath accepts element this cycle
elem_idx  output  IDX_W  current element index
elem_last  output  1  offered element is the final one
wb_valid  input  1  one element retired this cycle
abort  input  1  cancel current instruction
busy  output  1  state != IDLE
done  output  1  one-cycle completion pulse
err  output  1  sticky: writeback received with nothing outstanding

Behaviour:
- Single clock, synchronous active-high reset. On reset:
  - state=IDLE, issue_cnt=0, wb_cnt=0, vlen_q=0, err=0.
  - cmd_ready=1, elem_valid=0, elem_last=0, busy=0, done=0.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid: latch vlen_q = min(cmd_vlen, MAX_VLEN) and clear both counters.
  - If vlen_q==0, go to DONE; otherwise go to RUN.
- RUN:
  - elem_valid=1, elem_idx=issue_cnt[IDX_W-1:0], elem_last=(issue_cnt==vlen_q-1).
  - issue_cnt increments only on elem_valid&&elem_ready.
  - elem_idx and elem_last stay stable while stalled.
  - Acceptance of the last element goes to DRAIN, or straight to DONE if wb_cnt+wb_valid already equals vlen_q.
- DRAIN:
  - elem_valid=0.
  - Stay until wb_cnt==vlen_q, counting wb_valid along the way; then go to DONE.
- DONE:
  - done=1 for exactly one cycle, then IDLE.
  - cmd_ready=0 in DONE, so back-to-back commands have a 1-cycle bubble.
- Latency:
  - Command accepted in cycle N gives the first elem_valid in N+1.
  - Final wb_valid in cycle M gives done in M+1.
  - vlen=0 accepted in N gives done in N+1.
- Writeback counting:
  - wb_cnt increments on wb_valid when wb_cnt < issue_cnt, or when a same-cycle issue makes the element outstanding.
  - Otherwise wb_valid is dropped and err sets (cleared only by reset).
- Simultaneous issue and writeback in one cycle: both counters update.
- Counters never wrap. issue_cnt saturates at vlen_q; CNT_W holds MAX_VLEN exactly.
- cmd_vlen > MAX_VLEN clamps to MAX_VLEN.
- Abort:
  - Asserted in any state, abort forces IDLE next cycle, clears counters, and suppresses done.
  - abort takes priority over cmd_valid in IDLE (the command is not accepted).
- Reset mid-operation behaves like abort, and also clears err.
- cmd_vlen is sampled only at acceptance. Later changes are ignored.

Decomposition:
- Package vec_seq_pkg: state enum type (IDLE, RUN, DRAIN, DONE) and the MAX_VLEN default constant.
- Sub-module vec_idx_counter (WIDTH, synchronous clear, enable, limit input, output at_limit) instantiated twice, for issue_cnt and wb_cnt.
- FSM and handshake logic live in vec_elem_seq.

Test Plan:
- vlen=4, elem_ready=1, wb_valid one cycle after each issue -> elem_idx 0,1,2,3 on consecutive cycles; elem_last only with idx 3; done pulses one cycle after the 4th wb; err=0.
- vlen=3, elem_ready toggling 1,0,1,0,1 -> idx holds stable during stalls; 3 accepted elements; elem_valid drops after the 3rd accept.
- vlen=0 -> cmd accepted, no elem_valid ever, done pulses the next cycle, then cmd_ready=1.
- cmd_vlen=20 with MAX_VLEN=16 -> exactly 16 elements issued (idx 0..15); done after 16 writebacks.
- vlen=8, abort after 3 accepts -> IDLE next cycle, no done, cmd_ready=1. A new vlen=2 command then issues idx 0,1.
- wb_valid in IDLE -> err=1 and stays 1 through a later normal vlen=2 run; reset clears it to 0.
